// File: rtl/sdram_port_arbiter.sv
// Two-requester front end for one toggle-handshake SDRAM port: Oric CPU strobes and FDC DMA.
// CPU wins arbitration; a streak counter caps consecutive CPU grants while the FDC waits.
module sdram_port_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned CPU_STREAK = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cpu_cs,
    input  logic          cpu_oe,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_d,
    output logic [7:0]    cpu_q,
    input  logic          fdc_req,
    input  logic          fdc_we,
    input  logic [AW-1:0] fdc_a,
    input  logic [7:0]    fdc_d,
    output logic [7:0]    fdc_q,
    output logic          fdc_ack,
    output logic          fdc_busy,
    output logic          cpu_overrun,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [AW-2:0] mem_a,
    output logic [1:0]    mem_ds,
    output logic          mem_we,
    output logic [15:0]   mem_d,
    input  logic [15:0]   mem_q
);

    typedef enum logic [1:0] {StIdle, StCpuWait, StFdcWait} state_e;

    localparam logic [3:0] StreakMax = 4'(CPU_STREAK);

    state_e          state_q, state_d;
    logic            rd_prev_q, wr_prev_q;
    logic [AW-1:0]   a_prev_q;
    logic            cpu_pend_q, cpu_we_q;
    logic [AW-1:0]   cpu_a_q;
    logic [7:0]      cpu_d_q;
    logic            fdc_pend_q, fdc_we_q;
    logic [AW-1:0]   fdc_a_q;
    logic [7:0]      fdc_d_q;
    logic [3:0]      streak_q;
    logic            overrun_q;
    logic            mem_req_q, mem_we_q, byte_sel_q;
    logic [AW-2:0]   mem_a_q;
    logic [1:0]      mem_ds_q;
    logic [15:0]     mem_d_q;
    logic [7:0]      cpu_rdata_q, fdc_rdata_q;
    logic            fdc_ack_q;

    logic cpu_rd, cpu_wr, cpu_event, mem_idle, fdc_accept;
    logic grant_cpu, grant_fdc, done;
    logic [7:0] rd_byte;

    assign cpu_rd     = cpu_cs & cpu_oe;
    assign cpu_wr     = cpu_cs & cpu_we;
    assign cpu_event  = (cpu_rd & ~rd_prev_q) | (cpu_wr & ~wr_prev_q) |
                        (cpu_rd & (cpu_a != a_prev_q));
    assign mem_idle   = (mem_ack == mem_req_q);
    assign fdc_busy   = fdc_pend_q | (state_q == StFdcWait) | fdc_ack_q;
    assign fdc_accept = fdc_req & ~fdc_busy;
    assign rd_byte    = byte_sel_q ? mem_q[15:8] : mem_q[7:0];

    always_comb begin
        state_d   = state_q;
        grant_cpu = 1'b0;
        grant_fdc = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_idle) begin
                    if (fdc_pend_q && (!cpu_pend_q || streak_q == StreakMax)) begin
                        grant_fdc = 1'b1;
                        state_d   = StFdcWait;
                    end else if (cpu_pend_q) begin
                        grant_cpu = 1'b1;
                        state_d   = StCpuWait;
                    end
                end
            end
            StCpuWait, StFdcWait: begin
                if (mem_idle) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= StIdle;
            rd_prev_q   <= 1'b0;
            wr_prev_q   <= 1'b0;
            a_prev_q    <= '0;
            cpu_pend_q  <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_a_q     <= '0;
            cpu_d_q     <= '0;
            fdc_pend_q  <= 1'b0;
            fdc_we_q    <= 1'b0;
            fdc_a_q     <= '0;
            fdc_d_q     <= '0;
            streak_q    <= '0;
            overrun_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            byte_sel_q  <= 1'b0;
            mem_a_q     <= '0;
            mem_ds_q    <= 2'b11;
            mem_d_q     <= '0;
            cpu_rdata_q <= '0;
            fdc_rdata_q <= '0;
            fdc_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_prev_q <= cpu_rd;
            wr_prev_q <= cpu_wr;
            a_prev_q  <= cpu_a;
            fdc_ack_q <= done && (state_q == StFdcWait);

            // Latest CPU event wins; losing an unissued one is flagged.
            if (cpu_event) begin
                cpu_a_q    <= cpu_a;
                cpu_we_q   <= cpu_we;
                cpu_d_q    <= cpu_d;
                cpu_pend_q <= 1'b1;
                if (cpu_pend_q && !grant_cpu) overrun_q <= 1'b1;
            end else if (grant_cpu) begin
                cpu_pend_q <= 1'b0;
            end

            if (fdc_accept) begin
                fdc_a_q    <= fdc_a;
                fdc_we_q   <= fdc_we;
                fdc_d_q    <= fdc_d;
                fdc_pend_q <= 1'b1;
            end else if (grant_fdc) begin
                fdc_pend_q <= 1'b0;
            end

            if (grant_cpu) begin
                mem_req_q  <= ~mem_req_q;
                mem_a_q    <= cpu_a_q[AW-1:1];
                mem_we_q   <= cpu_we_q;
                mem_ds_q   <= cpu_we_q ? (cpu_a_q[0] ? 2'b10 : 2'b01) : 2'b11;
                mem_d_q    <= {cpu_d_q, cpu_d_q};
                byte_sel_q <= cpu_a_q[0];
                if (!fdc_pend_q) streak_q <= '0;
                else if (streak_q < StreakMax) streak_q <= streak_q + 4'd1;
            end else if (grant_fdc) begin
                mem_req_q  <= ~mem_req_q;
                mem_a_q    <= fdc_a_q[AW-1:1];
                mem_we_q   <= fdc_we_q;
                mem_ds_q   <= fdc_we_q ? (fdc_a_q[0] ? 2'b10 : 2'b01) : 2'b11;
                mem_d_q    <= {fdc_d_q, fdc_d_q};
                byte_sel_q <= fdc_a_q[0];
                streak_q   <= '0;
            end

            if (done && !mem_we_q) begin
                if (state_q == StCpuWait) cpu_rdata_q <= rd_byte;
                else fdc_rdata_q <= rd_byte;
            end
        end
    end

    assign cpu_q       = cpu_rdata_q;
    assign fdc_q       = fdc_rdata_q;
    assign fdc_ack     = fdc_ack_q;
    assign cpu_overrun = overrun_q;
    assign mem_req     = mem_req_q;
    assign mem_a       = mem_a_q;
    assign mem_ds      = mem_ds_q;
    assign mem_we      = mem_we_q;
    assign mem_d       = mem_d_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a toggle-handshake SDRAM responder model.
module tb_sdram_port_arbiter;

    localparam int AW = 16;
    localparam int CPU_STREAK = 4;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_a = '0;
    logic [7:0]    cpu_d = '0;
    logic [7:0]    cpu_q;
    logic          fdc_req = 1'b0, fdc_we = 1'b0;
    logic [AW-1:0] fdc_a = '0;
    logic [7:0]    fdc_d = '0;
    logic [7:0]    fdc_q;
    logic          fdc_ack, fdc_busy, cpu_overrun, mem_req;
    logic          mem_ack = 1'b0;
    logic [AW-2:0] mem_a;
    logic [1:0]    mem_ds;
    logic          mem_we;
    logic [15:0]   mem_d;
    logic [15:0]   mem_q = '0;

    int   checks = 0;
    int   errors = 0;
    int   resp_lat = 2;
    int   resp_cnt = 0;
    logic force_en = 1'b1;
    logic force_val = 1'b0;

    sdram_port_arbiter #(.AW(AW), .CPU_STREAK(CPU_STREAK)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q(cpu_q),
        .fdc_req(fdc_req), .fdc_we(fdc_we), .fdc_a(fdc_a), .fdc_d(fdc_d), .fdc_q(fdc_q),
        .fdc_ack(fdc_ack), .fdc_busy(fdc_busy), .cpu_overrun(cpu_overrun),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_ds(mem_ds),
        .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM model: acknowledges resp_lat negedges after a request toggle, unless forced.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (force_en) begin
                mem_ack = force_val;
                resp_cnt = 0;
            end else if (mem_ack !== mem_req) begin
                resp_cnt++;
                if (resp_cnt >= resp_lat) begin
                    mem_ack = mem_req;
                    resp_cnt = 0;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        force_en = 1'b1;
        force_val = 1'b0;
        repeat (3) tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0h want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0h want 0", mem_we); end
        checks++; if (mem_a !== 15'h0) begin errors++; $display("FAIL reset_mem_a got %0h want 0", mem_a); end
        checks++; if (mem_ds !== 2'b11) begin errors++; $display("FAIL reset_mem_ds got %0b want 11", mem_ds); end
        checks++; if (mem_d !== 16'h0) begin errors++; $display("FAIL reset_mem_d got %0h want 0", mem_d); end
        checks++; if (cpu_q !== 8'h0) begin errors++; $display("FAIL reset_cpu_q got %0h want 0", cpu_q); end
        checks++; if (fdc_q !== 8'h0) begin errors++; $display("FAIL reset_fdc_q got %0h want 0", fdc_q); end
        checks++; if (fdc_ack !== 1'b0) begin errors++; $display("FAIL reset_fdc_ack got %0h want 0", fdc_ack); end
        checks++; if (fdc_busy !== 1'b0) begin errors++; $display("FAIL reset_fdc_busy got %0h want 0", fdc_busy); end
        checks++; if (cpu_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0h want 0", cpu_overrun); end
        reset = 1'b0;
        tick();
        force_en = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        logic prev;
        prev = mem_req;
        mem_q = 16'hA55A;
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 16'h1235;
        tick();
        checks++; if (mem_req !== prev) begin errors++; $display("FAIL rd_early_issue got %0h want %0h", mem_req, prev); end
        tick();
        checks++; if (mem_req !== ~prev) begin errors++; $display("FAIL rd_issue_cycle got %0h want %0h", mem_req, ~prev); end
        checks++; if (mem_a !== 15'h091A) begin errors++; $display("FAIL rd_mem_a got %0h want 091a", mem_a); end
        checks++; if (mem_ds !== 2'b11) begin errors++; $display("FAIL rd_mem_ds got %0b want 11", mem_ds); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we got %0h want 0", mem_we); end
        for (int i = 0; i < 20 && mem_ack !== mem_req; i++) tick();
        tick();
        checks++; if (cpu_q !== 8'hA5) begin errors++; $display("FAIL rd_cpu_q got %0h want a5", cpu_q); end
        cpu_oe = 1'b0; cpu_cs = 1'b0;
        tick();
    endtask

    task automatic test_cpu_write();
        logic prev;
        prev = mem_req;
        mem_q = 16'h1234;
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_a = 16'h0400; cpu_d = 8'h3C;
        tick();
        tick();
        checks++; if (mem_req !== ~prev) begin errors++; $display("FAIL wr_issue got %0h want %0h", mem_req, ~prev); end
        checks++; if (mem_ds !== 2'b01) begin errors++; $display("FAIL wr_mem_ds got %0b want 01", mem_ds); end
        checks++; if (mem_d !== 16'h3C3C) begin errors++; $display("FAIL wr_mem_d got %0h want 3c3c", mem_d); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we got %0h want 1", mem_we); end
        checks++; if (mem_a !== 15'h0200) begin errors++; $display("FAIL wr_mem_a got %0h want 0200", mem_a); end
        for (int i = 0; i < 20 && mem_ack !== mem_req; i++) tick();
        tick();
        checks++; if (cpu_q !== 8'hA5) begin errors++; $display("FAIL wr_cpu_q_kept got %0h want a5", cpu_q); end
        cpu_we = 1'b0; cpu_cs = 1'b0;
        tick();
    endtask

    task automatic test_fdc_read();
        logic last;
        int   toggles, acks;
        bit   after_ack;
        last = mem_req;
        toggles = 0; acks = 0; after_ack = 0;
        mem_q = 16'h7E00;
        fdc_req = 1'b1; fdc_we = 1'b0; fdc_a = 16'h8001; fdc_d = 8'h00;
        tick();
        checks++; if (fdc_busy !== 1'b1) begin errors++; $display("FAIL fdc_busy_rise got %0h want 1", fdc_busy); end
        fdc_a = 16'h0002;  // second request while busy: must be dropped
        tick();
        fdc_req = 1'b0;
        checks++; if (mem_a !== 15'h4000) begin errors++; $display("FAIL fdc_mem_a got %0h want 4000", mem_a); end
        for (int i = 0; i < 20; i++) begin
            if (mem_req !== last) begin toggles++; last = mem_req; end
            if (after_ack) begin
                checks++; if (fdc_busy !== 1'b0) begin errors++; $display("FAIL fdc_busy_fall got %0h want 0", fdc_busy); end
                after_ack = 0;
            end
            if (fdc_ack === 1'b1) begin
                acks++;
                after_ack = 1;
                checks++; if (fdc_q !== 8'h7E) begin errors++; $display("FAIL fdc_q got %0h want 7e", fdc_q); end
                checks++; if (fdc_busy !== 1'b1) begin errors++; $display("FAIL fdc_busy_at_ack got %0h want 1", fdc_busy); end
            end
            tick();
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL fdc_ack_count got %0d want 1", acks); end
        checks++; if (toggles != 1) begin errors++; $display("FAIL fdc_access_count got %0d want 1", toggles); end
    endtask

    task automatic test_overrun();
        logic          last;
        int            toggles;
        logic [AW-2:0] last_a;
        toggles = 0; last_a = '0;
        checks++; if (cpu_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0h want 0", cpu_overrun); end
        resp_lat = 8;
        fdc_req = 1'b1; fdc_we = 1'b0; fdc_a = 16'h0050;
        tick();
        fdc_req = 1'b0;
        tick();
        checks++; if (mem_a !== 15'h0028) begin errors++; $display("FAIL ovr_fdc_grant got %0h want 0028", mem_a); end
        last = mem_req;
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 16'h0010;
        tick();
        cpu_oe = 1'b0;
        tick();
        cpu_oe = 1'b1; cpu_a = 16'h0020;
        tick();
        tick();
        checks++; if (cpu_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %0h want 1", cpu_overrun); end
        for (int i = 0; i < 30; i++) begin
            if (mem_req !== last) begin toggles++; last = mem_req; last_a = mem_a; end
            tick();
        end
        checks++; if (toggles != 1) begin errors++; $display("FAIL ovr_cpu_accesses got %0d want 1", toggles); end
        checks++; if (last_a !== 15'h0010) begin errors++; $display("FAIL ovr_cpu_addr got %0h want 0010", last_a); end
        cpu_oe = 1'b0; cpu_cs = 1'b0;
        resp_lat = 2;
        tick();
    endtask

    task automatic test_starvation();
        logic last;
        int   cpu_grants;
        bit   fdc_seen;
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 16'h0100;
        for (int r = 0; r < 2; r++) begin
            last = mem_req;
            for (int i = 0; i < 20; i++) begin
                cpu_a = cpu_a + 16'd2;
                tick();
                if (mem_req !== last) break;
            end
            last = mem_req;
            cpu_grants = 0; fdc_seen = 0;
            fdc_req = 1'b1; fdc_we = 1'b0; fdc_a = 16'hF000;
            for (int i = 0; i < 60 && !fdc_seen; i++) begin
                cpu_a = cpu_a + 16'd2;
                tick();
                fdc_req = 1'b0;
                if (mem_req !== last) begin
                    last = mem_req;
                    if (mem_a === 15'h7800) fdc_seen = 1;
                    else cpu_grants++;
                end
            end
            checks++; if (!fdc_seen) begin errors++; $display("FAIL starve_fdc_round%0d got 0 want 1", r); end
            checks++; if (cpu_grants != CPU_STREAK) begin errors++; $display("FAIL starve_streak_round%0d got %0d want %0d", r, cpu_grants, CPU_STREAK); end
            for (int i = 0; i < 30 && fdc_busy !== 1'b0; i++) begin
                cpu_a = cpu_a + 16'd2;
                tick();
            end
        end
        cpu_oe = 1'b0; cpu_cs = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        logic prev;
        force_val = mem_ack;
        force_en = 1'b1;
        prev = mem_req;
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 16'h0300;
        tick();
        tick();
        checks++; if (mem_req !== ~prev) begin errors++; $display("FAIL rst_mid_issue got %0h want %0h", mem_req, ~prev); end
        mem_q = 16'h1111;
        reset = 1'b1; force_val = 1'b1; cpu_cs = 1'b0; cpu_oe = 1'b0;
        tick();
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_req got %0h want 0", mem_req); end
        checks++; if (mem_ds !== 2'b11) begin errors++; $display("FAIL rst_mid_mem_ds got %0b want 11", mem_ds); end
        checks++; if (mem_a !== 15'h0) begin errors++; $display("FAIL rst_mid_mem_a got %0h want 0", mem_a); end
        checks++; if (cpu_q !== 8'h0) begin errors++; $display("FAIL rst_mid_cpu_q got %0h want 0", cpu_q); end
        checks++; if (cpu_overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun got %0h want 0", cpu_overrun); end
        checks++; if (fdc_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_fdc_busy got %0h want 0", fdc_busy); end
        reset = 1'b0;
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 16'h0302;
        repeat (4) tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_stale_ack_issue got %0h want 0", mem_req); end
        force_val = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_reissue got %0h want 1", mem_req); end
        checks++; if (mem_a !== 15'h0181) begin errors++; $display("FAIL rst_mid_reissue_a got %0h want 0181", mem_a); end
        checks++; if (cpu_q !== 8'h0) begin errors++; $display("FAIL rst_mid_cpu_q_kept got %0h want 0", cpu_q); end
        cpu_oe = 1'b0; cpu_cs = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_fdc_read();
        test_overrun();
        test_starvation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
